// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline register: formats load data, flags misaligned/illegal loads,
// and counts retired instructions. Every output comes straight from a flop.
module mem_wb_stage #(
   parameter int XLEN = 32,
   parameter int REGW = 5
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            stall,
   input  logic            flush,
   input  logic            m_valid,
   input  logic [REGW-1:0] m_rd,
   input  logic            m_reg_write,
   input  logic            m_mem_to_reg,
   input  logic [2:0]      m_funct3,
   input  logic [XLEN-1:0] m_alu_result,
   input  logic [XLEN-1:0] m_read_data,
   output logic            w_valid,
   output logic [REGW-1:0] w_rd,
   output logic            w_reg_write,
   output logic [XLEN-1:0] w_data,
   output logic            w_misaligned,
   output logic            err_sticky,
   input  logic            clr_err,
   output logic [31:0]     retire_cnt
);

   logic            valid_q, valid_d;
   logic [REGW-1:0] rd_q, rd_d;
   logic            regWrite_q, regWrite_d;
   logic [XLEN-1:0] data_q, data_d;
   logic            misaligned_q, misaligned_d;
   logic            err_q, err_d;
   logic [31:0]     retire_cnt_q, retire_cnt_d;

   logic [1:0]      offset;
   logic            isLoad, misaligned, illegal, capture;
   logic [7:0]      loadByte;
   logic [15:0]     loadHalf;
   logic [XLEN-1:0] loadData;

   assign offset  = m_alu_result[1:0];
   assign isLoad  = m_valid & m_mem_to_reg;
   assign capture = ~flush & ~stall;

   // Load formatting; illegal funct3 values fall through to the raw word.
   always_comb begin
      loadByte   = m_read_data[8*offset +: 8];
      loadHalf   = m_read_data[16*offset[1] +: 16];
      misaligned = 1'b0;
      illegal    = 1'b0;
      loadData   = m_read_data;
      case (m_funct3)
         3'b000: loadData = {{(XLEN-8){loadByte[7]}}, loadByte};
         3'b001: begin
            loadData   = {{(XLEN-16){loadHalf[15]}}, loadHalf};
            misaligned = isLoad & offset[0];
         end
         3'b010: misaligned = isLoad & (offset != 2'b00);
         3'b100: loadData = {{(XLEN-8){1'b0}}, loadByte};
         3'b101: begin
            loadData   = {{(XLEN-16){1'b0}}, loadHalf};
            misaligned = isLoad & offset[0];
         end
         default: illegal = isLoad;
      endcase
   end

   // Next-state selection: flush beats stall beats a normal capture.
   always_comb begin
      valid_d      = valid_q;
      rd_d         = rd_q;
      regWrite_d   = regWrite_q;
      data_d       = data_q;
      misaligned_d = 1'b0;
      if (flush) begin
         valid_d    = 1'b0;
         regWrite_d = 1'b0;
      end else if (!stall) begin
         valid_d      = m_valid;
         rd_d         = m_rd;
         regWrite_d   = m_valid & m_reg_write & (m_rd != '0) & ~misaligned & ~illegal;
         data_d       = m_mem_to_reg ? loadData : m_alu_result;
         misaligned_d = misaligned;
      end
      err_d        = (capture & (misaligned | illegal)) | (err_q & ~clr_err);
      retire_cnt_d = retire_cnt_q + {31'd0, capture & m_valid};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_q      <= 1'b0;
         rd_q         <= '0;
         regWrite_q   <= 1'b0;
         data_q       <= '0;
         misaligned_q <= 1'b0;
         err_q        <= 1'b0;
         retire_cnt_q <= '0;
      end else begin
         valid_q      <= valid_d;
         rd_q         <= rd_d;
         regWrite_q   <= regWrite_d;
         data_q       <= data_d;
         misaligned_q <= misaligned_d;
         err_q        <= err_d;
         retire_cnt_q <= retire_cnt_d;
      end
   end

   assign w_valid      = valid_q;
   assign w_rd         = rd_q;
   assign w_reg_write  = regWrite_q;
   assign w_data       = data_q;
   assign w_misaligned = misaligned_q;
   assign err_sticky   = err_q;
   assign retire_cnt   = retire_cnt_q;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Bench for mem_wb_stage: directed literal cases plus random traffic checked
// cycle by cycle against a behavioural model of the writeback slot.
module tb_mem_wb_stage;

   logic        clk, rst_n, stall, flush, clr_err;
   logic        m_valid, m_reg_write, m_mem_to_reg;
   logic [4:0]  m_rd;
   logic [2:0]  m_funct3;
   logic [31:0] m_alu_result, m_read_data;
   logic        w_valid, w_reg_write, w_misaligned, err_sticky;
   logic [4:0]  w_rd;
   logic [31:0] w_data, retire_cnt;

   int total = 0;
   int bad   = 0;
   int preloadReq = 0;
   int preloadSeen = 0;

   bit          eValid, eWe, eMis, eErr;
   int unsigned eRd;
   logic [31:0] eData, eCnt;

   mem_wb_stage #(.XLEN(32), .REGW(5)) dut (
      .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush),
      .m_valid(m_valid), .m_rd(m_rd), .m_reg_write(m_reg_write),
      .m_mem_to_reg(m_mem_to_reg), .m_funct3(m_funct3),
      .m_alu_result(m_alu_result), .m_read_data(m_read_data),
      .w_valid(w_valid), .w_rd(w_rd), .w_reg_write(w_reg_write),
      .w_data(w_data), .w_misaligned(w_misaligned), .err_sticky(err_sticky),
      .clr_err(clr_err), .retire_cnt(retire_cnt)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("[TB] FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   // Load result as the ISA defines it: pick the addressed byte/half and extend.
   function automatic logic [31:0] formatLoad(input logic [2:0] f3, input int unsigned a,
                                              input logic [31:0] word);
      logic [31:0] b, h;
      b = (word >> (8 * a)) & 32'hFF;
      h = (word >> (16 * (a / 2))) & 32'hFFFF;
      case (f3)
         3'd0:    return (b >= 32'h80) ? (b | 32'hFFFF_FF00) : b;
         3'd1:    return (h >= 32'h8000) ? (h | 32'hFFFF_0000) : h;
         3'd4:    return b;
         3'd5:    return h;
         default: return word;
      endcase
   endfunction

   // Reference model of the writeback slot, advanced once per clock.
   always @(posedge clk or negedge rst_n) begin
      int unsigned a;
      bit isLoad, mis, ill;
      if (!rst_n) begin
         eValid = 0; eRd = 0; eWe = 0; eData = 0; eMis = 0; eErr = 0; eCnt = 0;
         preloadSeen = preloadReq;
      end else begin
         if (preloadSeen != preloadReq) begin
            eCnt = 32'hFFFF_FFFF;
            preloadSeen = preloadReq;
         end
         a      = m_alu_result % 4;
         isLoad = m_valid && m_mem_to_reg;
         mis    = isLoad && ((((m_funct3 == 1) || (m_funct3 == 5)) && (a % 2 == 1)) ||
                             ((m_funct3 == 2) && (a != 0)));
         ill    = isLoad && ((m_funct3 == 3) || (m_funct3 == 6) || (m_funct3 == 7));
         eMis   = 0;
         if (flush) begin
            eValid = 0;
            eWe    = 0;
         end else if (!stall) begin
            eValid = m_valid;
            eRd    = m_rd;
            eWe    = m_valid && m_reg_write && (m_rd != 0) && !mis && !ill;
            eData  = m_mem_to_reg ? formatLoad(m_funct3, a, m_read_data) : m_alu_result;
            eMis   = mis;
            if (m_valid) eCnt = eCnt + 1;
         end
         if (!flush && !stall && (mis || ill)) eErr = 1;
         else if (clr_err) eErr = 0;
      end
   end

   // Cycle-by-cycle comparison shortly after every active edge.
   always @(posedge clk) begin
      #1;
      if (rst_n) begin
         checkOutput("w_valid", {31'd0, w_valid}, {31'd0, eValid});
         checkOutput("w_rd", {27'd0, w_rd}, eRd);
         checkOutput("w_reg_write", {31'd0, w_reg_write}, {31'd0, eWe});
         checkOutput("w_data", w_data, eData);
         checkOutput("w_misaligned", {31'd0, w_misaligned}, {31'd0, eMis});
         checkOutput("err_sticky", {31'd0, err_sticky}, {31'd0, eErr});
         checkOutput("retire_cnt", retire_cnt, eCnt);
      end
   end

   // Drive one cycle of inputs at the falling edge, return just after the rising edge.
   task automatic applyStimulus(input bit st, input bit fl, input bit clr, input bit v,
                                input logic [4:0] rd, input bit we, input bit m2r,
                                input logic [2:0] f3, input logic [31:0] alu,
                                input logic [31:0] rdata);
      @(negedge clk);
      stall = st; flush = fl; clr_err = clr;
      m_valid = v; m_rd = rd; m_reg_write = we; m_mem_to_reg = m2r;
      m_funct3 = f3; m_alu_result = alu; m_read_data = rdata;
      @(posedge clk);
      #1;
   endtask

   task automatic checkAllZero(input string tag);
      checkOutput({tag, "_valid"}, {31'd0, w_valid}, 32'd0);
      checkOutput({tag, "_rd"}, {27'd0, w_rd}, 32'd0);
      checkOutput({tag, "_we"}, {31'd0, w_reg_write}, 32'd0);
      checkOutput({tag, "_data"}, w_data, 32'd0);
      checkOutput({tag, "_mis"}, {31'd0, w_misaligned}, 32'd0);
      checkOutput({tag, "_err"}, {31'd0, err_sticky}, 32'd0);
      checkOutput({tag, "_cnt"}, retire_cnt, 32'd0);
   endtask

   initial begin
      rst_n = 1'b0; stall = 0; flush = 0; clr_err = 0;
      m_valid = 0; m_rd = 0; m_reg_write = 0; m_mem_to_reg = 0;
      m_funct3 = 0; m_alu_result = 0; m_read_data = 0;
      #3;
      checkAllZero("reset");
      @(negedge clk);
      rst_n = 1'b1;

      // Signed byte load from the top byte lane.
      applyStimulus(0, 0, 0, 1, 5'd5, 1, 1, 3'b000, 32'h103, 32'h80FF_1234);
      checkOutput("lb_data", w_data, 32'hFFFF_FF80);
      checkOutput("lb_we", {31'd0, w_reg_write}, 32'd1);
      checkOutput("lb_cnt", retire_cnt, 32'd1);

      applyStimulus(0, 0, 0, 1, 5'd6, 1, 1, 3'b101, 32'h102, 32'h8001_FFFF);
      checkOutput("lhu_data", w_data, 32'h0000_8001);

      applyStimulus(0, 0, 0, 1, 5'd6, 1, 1, 3'b001, 32'h101, 32'h8001_FFFF);
      checkOutput("lh_mis", {31'd0, w_misaligned}, 32'd1);
      checkOutput("lh_we", {31'd0, w_reg_write}, 32'd0);
      checkOutput("lh_err", {31'd0, err_sticky}, 32'd1);
      checkOutput("lh_data", w_data, 32'hFFFF_FFFF);

      applyStimulus(0, 0, 0, 1, 5'd0, 1, 0, 3'b000, 32'h1234, 32'hAAAA_5555);
      checkOutput("alu_data", w_data, 32'h1234);
      checkOutput("alu_we", {31'd0, w_reg_write}, 32'd0);
      checkOutput("alu_valid", {31'd0, w_valid}, 32'd1);
      checkOutput("mis_pulse_end", {31'd0, w_misaligned}, 32'd0);

      for (int i = 0; i < 3; i++) begin
         applyStimulus(1, 0, 0, 1, 5'd9, 1, 0, 3'b000, 32'h5555 + i, 32'h0);
         checkOutput("stall_data", w_data, 32'h1234);
         checkOutput("stall_cnt", retire_cnt, 32'd4);
      end
      applyStimulus(1, 1, 0, 1, 5'd9, 1, 0, 3'b000, 32'h7777, 32'h0);
      checkOutput("flush_valid", {31'd0, w_valid}, 32'd0);
      checkOutput("flush_we", {31'd0, w_reg_write}, 32'd0);
      checkOutput("flush_data", w_data, 32'h1234);

      // Illegal load captured while clearing: the set must win.
      applyStimulus(0, 0, 1, 1, 5'd7, 1, 1, 3'b110, 32'h200, 32'hDEAD_BEEF);
      checkOutput("ill_data", w_data, 32'hDEAD_BEEF);
      checkOutput("ill_we", {31'd0, w_reg_write}, 32'd0);
      checkOutput("ill_err", {31'd0, err_sticky}, 32'd1);
      checkOutput("ill_cnt", retire_cnt, 32'd5);
      applyStimulus(0, 0, 1, 0, 5'd0, 0, 0, 3'b000, 32'h0, 32'h0);
      checkOutput("clr_err", {31'd0, err_sticky}, 32'd0);

      @(negedge clk);
      dut.retire_cnt_q = 32'hFFFF_FFFF;
      preloadReq++;
      applyStimulus(0, 0, 0, 1, 5'd3, 1, 0, 3'b000, 32'h42, 32'h0);
      checkOutput("cnt_wrap", retire_cnt, 32'd0);

      // Asynchronous reset between edges, held across a stall.
      applyStimulus(0, 0, 0, 1, 5'd4, 1, 0, 3'b000, 32'h99, 32'h0);
      #2 rst_n = 1'b0;
      #1 checkAllZero("async");
      applyStimulus(1, 0, 0, 1, 5'd8, 1, 0, 3'b000, 32'h77, 32'h0);
      @(negedge clk);
      rst_n = 1'b1;
      applyStimulus(0, 0, 0, 1, 5'd8, 1, 0, 3'b000, 32'h88, 32'h0);
      checkOutput("post_rst_valid", {31'd0, w_valid}, 32'd1);
      checkOutput("post_rst_data", w_data, 32'h88);
      checkOutput("post_rst_cnt", retire_cnt, 32'd1);

      for (int i = 0; i < 1500; i++) begin
         applyStimulus($urandom_range(0, 4) == 0, $urandom_range(0, 7) == 0,
                       $urandom_range(0, 5) == 0, $urandom_range(0, 3) != 0,
                       ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom),
                       1'($urandom), 1'($urandom), 3'($urandom), $urandom, $urandom);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
